// File: rtl/sinc_pkg.sv
// Shared constants and elaboration-time helpers for the sinc^N decimator.
// Covers the internal width function and the parameter legality checks.
package sinc_pkg;

    localparam int BIT_POS = 1;
    localparam int BIT_NEG = -1;

    function automatic int acc_width(input int order, input int dec_log2);
        return order * dec_log2 + 2;
    endfunction

    function automatic bit order_legal(input int order);
        return (order >= 1) && (order <= 5);
    endfunction

    function automatic bit dec_legal(input int dec_log2);
        return (dec_log2 >= 1) && (dec_log2 <= 12);
    endfunction

    function automatic bit out_w_legal(input int out_w, input int order, input int dec_log2);
        return (out_w >= 2) && (out_w <= order * dec_log2 + 1);
    endfunction

endpackage

// File: rtl/sinc_comb_stage.sv
// One CIC comb section: y = x - x_delayed, delay register advances on each decimation strobe.
module sinc_comb_stage #(
    parameter int ACC_W = 26
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] x,
    output logic signed [ACC_W-1:0] y
);

    logic signed [ACC_W-1:0] dly_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_p1 <= '0;
        end else if (clr) begin
            dly_p1 <= '0;
        end else if (en) begin
            dly_p1 <= x;
        end
    end

    assign y = x - dly_p1;

endmodule

// File: rtl/sinc_decimator.sv
// CIC/sinc^N decimator for a 1-bit delta-sigma stream: ORDER integrators at the input
// rate, ORDER combs at the decimated rate, positive clamp and truncation to OUT_W bits.
module sinc_decimator
    import sinc_pkg::*;
#(
    parameter int ORDER    = 3,
    parameter int DEC_LOG2 = 8,
    parameter int OUT_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    localparam int ACC_W = acc_width(ORDER, DEC_LOG2);
    localparam int SET_W = $clog2(ORDER + 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = {2'b00, {(ACC_W-2){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    if (!order_legal(ORDER)) begin : g_bad_order
        $error("sinc_decimator: ORDER must be in 1..5");
    end
    if (!dec_legal(DEC_LOG2)) begin : g_bad_dec
        $error("sinc_decimator: DEC_LOG2 must be in 1..12");
    end
    if (!out_w_legal(OUT_W, ORDER, DEC_LOG2)) begin : g_bad_out_w
        $error("sinc_decimator: OUT_W must be in 2..ORDER*DEC_LOG2+1");
    end

    // Only +R^N can exceed the signed range of the output slice; negatives fit exactly.
    function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] y);
        if (y > Y_MAX) begin
            return OUT_MAX;
        end
        return y[ACC_W-2 -: OUT_W];
    endfunction

    // Stage p0: integrators and decimation phase, advanced per accepted input bit
    logic signed [ACC_W-1:0] smp_p0;
    logic signed [ACC_W-1:0] int_p0 [ORDER];
    logic [DEC_LOG2-1:0]     cnt_p0;

    assign smp_p0 = in ? ACC_W'(BIT_POS) : ACC_W'(BIT_NEG);

    for (genvar k = 0; k < ORDER; k++) begin : g_int
        logic signed [ACC_W-1:0] addend;
        logic signed [ACC_W-1:0] acc;

        if (k == 0) begin : g_first
            assign addend = smp_p0;
        end else begin : g_next
            assign addend = int_p0[k-1];
        end

        // Wraps modulo 2^ACC_W by design; the combs cancel the wrap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (sync) begin
                acc <= '0;
            end else if (in_valid) begin
                acc <= acc + addend;
            end
        end

        assign int_p0[k] = acc;
    end

    // Stage p1: decimation strobe and comb chain on the last integrator
    logic                    vld_p1;
    logic signed [ACC_W-1:0] comb_p1 [ORDER+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            vld_p1 <= 1'b0;
        end else if (sync) begin
            cnt_p0 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid && (cnt_p0 == '1);
            if (in_valid) begin
                cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

    assign comb_p1[0] = int_p0[ORDER-1];

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        sinc_comb_stage #(
            .ACC_W (ACC_W)
        ) u_comb (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (sync),
            .en    (vld_p1),
            .x     (comb_p1[k]),
            .y     (comb_p1[k+1])
        );
    end

    // Stage p2: settling suppression and registered output
    logic [SET_W-1:0] settle;
    logic [OUT_W-1:0] out_p2;
    logic             vld_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= '0;
            out_p2 <= '0;
            vld_p2 <= 1'b0;
        end else if (sync) begin
            settle <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (vld_p1) begin
                if (settle == SET_W'(ORDER)) begin
                    out_p2 <= sat_out(comb_p1[ORDER]);
                    vld_p2 <= 1'b1;
                end else begin
                    settle <= settle + 1'b1;
                end
            end
        end
    end

    assign out       = out_p2;
    assign out_valid = vld_p2;

endmodule
